// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// The optional leading-zero blanking (BCD_LEADING_BLANK_EN) is applied in bcd_dabble.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Widest binary input whose maximum value still fits in 'digits' decimal digits.
  function automatic int max_bin_w(input int digits);
    longint unsigned lim;
    int              w;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    w = 0;
    while (w < 63 && ((64'd1 << (w + 1)) - 64'd1) < lim) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_dabble_if.sv
// Request/result bundle between the binary producer and the BCD converter.
interface bcd_dabble_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 8
);
  // start is a request sampled only while the converter is idle (no ready, no queueing);
  // valid is a one-cycle strobe with no backpressure, and bcd holds its value until the next strobe.
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input valid, input bcd);
  modport slave  (input start, input bin, output busy, output valid, output bcd);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit gets +3 when it is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

// File: rtl/bcd_dabble.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_LEADING_BLANK_EN to replace leading zero digits (above digit 0) with the blank code.
module bcd_dabble
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_dabble_if.slave  bus,
  output state_e       dbg_state
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [ACC_W-1:0] BCD_RST = ~(ACC_W'(4'hF));
`else
  localparam logic [ACC_W-1:0] BCD_RST = '0;
`endif

  if (BIN_W < 1 || BIN_W > max_bin_w(DIGITS)) begin : g_bad_width
    $error("bcd_dabble: BIN_W=%0d cannot be represented in %0d BCD digits", BIN_W, DIGITS);
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] bcd_q, bcd_d;
  logic             valid_q, valid_d;

  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] bcd_fmt;
  logic             lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[4*g +: 4])
    );
  end

  // Output formatting sits in front of the result register so latency matches in both builds.
  always_comb begin
    bcd_fmt = acc_q;
    lead    = 1'b1;
`ifdef BCD_LEADING_BLANK_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (acc_q[4*i +: 4] == 4'd0)) bcd_fmt[4*i +: 4] = BLANK_DIGIT;
      else                                   lead = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = bcd_fmt;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= BCD_RST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.valid  = valid_q;
  assign bus.bcd    = bcd_q;
  assign dbg_state  = state_e'(state_q);

endmodule

// File: tb/tb_bcd_dabble.sv
// Bench for bcd_dabble: directed and random conversions checked against a decimal reference model.
module tb_bcd_dabble;
  import bcd_pkg::*;

  localparam int BIN_W   = 8;
  localparam int DIGITS  = 8;
  localparam int LAT     = BIN_W + 1;
  localparam int W_BIN_W = 26;
  localparam int W_LAT   = W_BIN_W + 1;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [63:0] BCD_RST = 64'hFFFF_FFF0;
`else
  localparam logic [63:0] BCD_RST = 64'h0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_dabble_if #(.BIN_W(BIN_W),   .DIGITS(DIGITS)) nif ();
  bcd_dabble_if #(.BIN_W(W_BIN_W), .DIGITS(DIGITS)) wif ();
  state_e n_state, w_state;

  bcd_dabble #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (nif),
    .dbg_state (n_state)
  );

  bcd_dabble #(.BIN_W(W_BIN_W), .DIGITS(DIGITS)) u_dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (wif),
    .dbg_state (w_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain decimal digit extraction, then optional blanking above the top nonzero digit.
  function automatic logic [63:0] model(input longint unsigned v);
    logic [63:0] r;
    int          top;
    r   = '0;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      if (v % 10 != 0) top = i;
      v = v / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    for (int i = 1; i < DIGITS; i++) if (i > top) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  // scoreboard: every valid strobe consumes exactly one expected result
  always @(negedge clk) begin
    if (rst_n && nif.valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 64'(nif.bcd), 64'hDEAD);
      else begin
        mon_e = exp_q.pop_front();
        check("bcd_result", 64'(nif.bcd), mon_e);
      end
    end
  end

  // driver tasks (called at #1 after a rising edge)
  task automatic start_conv(input logic [7:0] b);
    nif.start = 1'b1;
    nif.bin   = b;
    exp_q.push_back(model(64'(b)));
    @(posedge clk); #1;
    nif.start = 1'b0;
    nif.bin   = 8'($urandom_range(0, 255));
    check("busy_after_accept", 64'(nif.busy), 64'd1);
  endtask

  task automatic wait_result(input bit poke);
    int n       = 0;
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    while (!seen && n < LAT + 20) begin
      n++;
      if (poke) begin
        nif.start = (n == 3 || n == 6);
        if (n == 3 || n == 6) nif.bin = 8'd99;
      end
      @(posedge clk); #1;
      if (nif.valid) seen = 1'b1;
      else if (!nif.busy) busy_ok = 1'b0;
    end
    nif.start = 1'b0;
    check("valid_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(LAT));
    check("busy_during", 64'(busy_ok), 64'd1);
    check("busy_clear", 64'(nif.busy), 64'd0);
  endtask

  task automatic wide_conv(input logic [25:0] b);
    int n    = 0;
    bit seen = 1'b0;
    wif.start = 1'b1;
    wif.bin   = b;
    @(posedge clk); #1;
    wif.start = 1'b0;
    wif.bin   = 26'($urandom);
    while (!seen && n < W_LAT + 20) begin
      n++;
      @(posedge clk); #1;
      if (wif.valid) seen = 1'b1;
    end
    check("w_latency", 64'(n), 64'(W_LAT));
    check("w_bcd", 64'(wif.bcd), model(64'(b)));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rb;
    logic [25:0] wb;
    nif.start = 1'b0; nif.bin = '0;
    wif.start = 1'b0; wif.bin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(nif.busy), 64'd0);
    check("rst_valid", 64'(nif.valid), 64'd0);
    check("rst_bcd", 64'(nif.bcd), BCD_RST);
    check("rst_w_bcd", 64'(wif.bcd), BCD_RST);
    check("rst_state", 64'(n_state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero, then hold and one-cycle strobe
    start_conv(8'd0);
    wait_result(1'b0);
    @(posedge clk); #1;
    check("valid_one_cycle", 64'(nif.valid), 64'd0);
    check("bcd_hold", 64'(nif.bcd), model(64'd0));

    start_conv(8'd120);
    wait_result(1'b0);

    // back-to-back: new start driven in the valid cycle
    start_conv(8'd255);
    wait_result(1'b0);
    start_conv(8'd1);
    wait_result(1'b0);

    // starts while busy with a changed bin are ignored
    start_conv(8'd200);
    wait_result(1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("no_extra_valid", 64'(exp_q.size()), 64'd0);

    // reset mid-conversion
    start_conv(8'd77);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(nif.busy), 64'd0);
    check("midrst_valid", 64'(nif.valid), 64'd0);
    check("midrst_bcd", 64'(nif.bcd), BCD_RST);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_bcd_hold", 64'(nif.bcd), BCD_RST);
    start_conv(8'd42);
    wait_result(1'b0);

    // random sweep
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom_range(0, 255));
      start_conv(rb);
      wait_result(1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // wide instance
    wide_conv(26'd67108863);
    wide_conv(26'd0);
    for (int i = 0; i < 10; i++) begin
      wb = 26'($urandom_range(0, 67108863));
      wide_conv(wb);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
